// File: rtl/dpram_frame_scheduler_if.sv
// Receive-writer and drain-engine handshake for the ping-pong DPRAM frame scheduler.
// The scheduler connects through the slave modport. The driver connects through the master modport.
interface dpram_frame_scheduler_if;
  logic        iRxDone;
  logic [15:0] iRxLen;
  logic        oRxBankValid;
  logic        oRxBank;
  logic        oRunStart;
  logic [15:0] oTxLen;
  logic        oRdBank;
  logic        iRunEnd;
  logic        oBusy;
  logic [7:0]  oDropCnt;
  logic [7:0]  oTimeoutCnt;
  logic [15:0] oFrameCnt;

  modport slave (
    input  iRxDone, iRxLen, iRunEnd,
    output oRxBankValid, oRxBank, oRunStart, oTxLen, oRdBank, oBusy,
           oDropCnt, oTimeoutCnt, oFrameCnt
  );

  modport master (
    output iRxDone, iRxLen, iRunEnd,
    input  oRxBankValid, oRxBank, oRunStart, oTxLen, oRdBank, oBusy,
           oDropCnt, oTimeoutCnt, oFrameCnt
  );
endinterface

// File: rtl/dpram_frame_scheduler.sv
// Ping-pong receive DPRAM bank allocator and drain sequencer.
// Completed frames are queued in FIFO order and launched one at a time into the byte FIFO drain engine.
module dpram_frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned MAX_LEN        = 1023
) (
  input logic                    iDm9000aClk,
  input logic                    iRst,
  dpram_frame_scheduler_if.slave bus
);

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] MaxLen  = 16'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][15:0] len_q, len_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [15:0]      tx_len_q, tx_len_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [15:0]      frame_q, frame_d;

  logic len_ok, rx_accept, rx_drop;
  logic launch, run_end, run_tmo;

  // All decisions use pre-edge full flags, so a bank freed this edge cannot absorb a frame.
  always_comb begin
    len_ok    = (bus.iRxLen != 16'd0) && (bus.iRxLen <= MaxLen);
    rx_accept = bus.iRxDone && !full_q[wr_ptr_q] && len_ok;
    rx_drop   = bus.iRxDone && !rx_accept;
  end

  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      full_q   <= '0;
      len_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      tx_len_q <= '0;
      drop_q   <= '0;
      tmo_q    <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tx_len_q <= tx_len_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
      frame_q  <= frame_d;
    end
  end

  // One counter serves as the RUN timeout and the RELEASE gap, cleared at each boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    run_end = 1'b0;
    run_tmo = 1'b0;
    case (state_q)
      StIdle: begin
        if (full_q[rd_ptr_q]) begin
          state_d = StRun;
          launch  = 1'b1;
        end
      end
      StRun: begin
        if (bus.iRunEnd) begin
          state_d = StRelease;
          cnt_d   = '0;
          run_end = 1'b1;
        end else if (cnt_q == TmoLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          run_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRelease: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    full_d   = full_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tx_len_d = tx_len_q;
    drop_d   = drop_q;
    tmo_d    = tmo_q;
    frame_d  = frame_q;
    if (rx_accept) begin
      full_d[wr_ptr_q] = 1'b1;
      len_d[wr_ptr_q]  = bus.iRxLen;
      wr_ptr_d         = ~wr_ptr_q;
    end
    // The read bank is full while RUN is active, so this clear never targets the bank being set above.
    if (run_end || run_tmo) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (launch) tx_len_d = len_q[rd_ptr_q];
    if (rx_drop && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;
    if (run_tmo && (tmo_q != 8'hff)) tmo_d = tmo_q + 8'd1;
    if (run_end) frame_d = frame_q + 16'd1;
  end

  always_comb begin
    bus.oRunStart    = (state_q == StRun);
    bus.oBusy        = (state_q != StIdle);
    bus.oRxBankValid = ~full_q[wr_ptr_q];
    bus.oRxBank      = wr_ptr_q;
    bus.oRdBank      = rd_ptr_q;
    bus.oTxLen       = tx_len_q;
    bus.oDropCnt     = drop_q;
    bus.oTimeoutCnt  = tmo_q;
    bus.oFrameCnt    = frame_q;
  end

endmodule

// File: tb/tb_dpram_frame_scheduler.sv
// Scoreboarded bench for dpram_frame_scheduler.
// Each accepted frame pushes {bank, len}. The entry is popped and checked when oRunStart rises.
module tb_dpram_frame_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_frame_scheduler_if bus ();

  dpram_frame_scheduler dut (
    .iDm9000aClk(clk),
    .iRst       (rst),
    .bus        (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] sb[$];
  logic [16:0] sb_e;
  logic        prev_run = 1'b0;
  int          n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic rx(input int len, input bit acc, input bit bank);
    bus.iRxDone = 1'b1;
    bus.iRxLen  = 16'(len);
    if (acc) sb.push_back({bank, 16'(len)});
    step(1);
    bus.iRxDone = 1'b0;
  endtask

  task automatic run_end_pulse();
    bus.iRunEnd = 1'b1;
    step(1);
    bus.iRunEnd = 1'b0;
  endtask

  task automatic wait_run(input logic level, input int budget, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.oRunStart !== level && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(bus.oRunStart), 32'(level));
  endtask

  // Scoreboard: every launch must match the oldest accepted frame.
  always @(negedge clk) begin
    if (bus.oRunStart === 1'b1 && !prev_run) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        check_eq("sb_tx_len", 32'(bus.oTxLen), 32'(sb_e[15:0]));
        check_eq("sb_rd_bank", 32'(bus.oRdBank), 32'(sb_e[16]));
      end
    end
    prev_run <= bus.oRunStart;
  end

  initial begin
    rst         = 1'b1;
    bus.iRxDone = 1'b0;
    bus.iRxLen  = '0;
    bus.iRunEnd = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_bank_valid", 32'(bus.oRxBankValid), 32'd1);
    check_eq("rst_rx_bank", 32'(bus.oRxBank), 32'd0);
    check_eq("rst_run_start", 32'(bus.oRunStart), 32'd0);
    check_eq("rst_tx_len", 32'(bus.oTxLen), 32'd0);
    check_eq("rst_rd_bank", 32'(bus.oRdBank), 32'd0);
    check_eq("rst_busy", 32'(bus.oBusy), 32'd0);
    check_eq("rst_drop", 32'(bus.oDropCnt), 32'd0);
    check_eq("rst_tmo", 32'(bus.oTimeoutCnt), 32'd0);
    check_eq("rst_frame", 32'(bus.oFrameCnt), 32'd0);

    // A run-end toggle in IDLE has no effect.
    step(1);
    bus.iRunEnd = 1'b1;
    step(3);
    bus.iRunEnd = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(bus.oBusy), 32'd0);
    check_eq("idle_frame", 32'(bus.oFrameCnt), 32'd0);

    // Single frame test.
    step(1);
    rx(64, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("sf_rx_bank", 32'(bus.oRxBank), 32'd1);
    check_eq("sf_not_started", 32'(bus.oRunStart), 32'd0);
    check_eq("sf_bank_valid", 32'(bus.oRxBankValid), 32'd1);
    step(1);
    @(negedge clk);
    check_eq("sf_run_start", 32'(bus.oRunStart), 32'd1);
    check_eq("sf_busy", 32'(bus.oBusy), 32'd1);
    step(298);
    run_end_pulse();
    @(negedge clk);
    check_eq("sf_gap1", 32'(bus.oRunStart), 32'd0);
    check_eq("sf_frame_cnt", 32'(bus.oFrameCnt), 32'd1);
    check_eq("sf_rd_bank", 32'(bus.oRdBank), 32'd1);
    step(1);
    @(negedge clk);
    check_eq("sf_gap2", 32'(bus.oRunStart), 32'd0);
    check_eq("sf_gap2_busy", 32'(bus.oBusy), 32'd1);
    step(1);
    @(negedge clk);
    check_eq("sf_idle", 32'(bus.oBusy), 32'd0);

    // Back-to-back frames, with an overflow arriving on the first release edge.
    step(1);
    rx(100, 1'b1, 1'b1);
    step(2);
    rx(200, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("bb_bank_valid_low", 32'(bus.oRxBankValid), 32'd0);
    step(5);
    bus.iRunEnd = 1'b1;
    bus.iRxDone = 1'b1;
    bus.iRxLen  = 16'd300;
    step(1);
    bus.iRunEnd = 1'b0;
    bus.iRxDone = 1'b0;
    @(negedge clk);
    check_eq("ov_drop_cnt", 32'(bus.oDropCnt), 32'd1);
    check_eq("ov_frame_cnt", 32'(bus.oFrameCnt), 32'd2);
    check_eq("bb_bank_valid_back", 32'(bus.oRxBankValid), 32'd1);
    check_eq("bb_released", 32'(bus.oRunStart), 32'd0);
    wait_run(1'b1, 10, "bb_second_start");
    step(20);
    run_end_pulse();
    wait_run(1'b0, 5, "bb_second_end");
    step(3);
    check_eq("bb_frame_cnt", 32'(bus.oFrameCnt), 32'd3);

    // Bad lengths are rejected and leave the write bank unchanged.
    rx(0, 1'b0, 1'b0);
    rx(1024, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("bl_drop_cnt", 32'(bus.oDropCnt), 32'd3);
    check_eq("bl_rx_bank", 32'(bus.oRxBank), 32'd1);
    check_eq("bl_bank_valid", 32'(bus.oRxBankValid), 32'd1);
    check_eq("bl_no_launch", 32'(bus.oRunStart), 32'd0);
    step(1);
    rx(1023, 1'b1, 1'b1);
    wait_run(1'b1, 5, "bl_start");
    step(10);
    run_end_pulse();
    wait_run(1'b0, 5, "bl_end");
    step(3);
    check_eq("bl_sb_drained", 32'(sb.size()), 32'd0);
    check_eq("bl_frame_cnt", 32'(bus.oFrameCnt), 32'd4);

    // Timeout test: iRunEnd is never asserted.
    rx(50, 1'b1, 1'b0);
    wait_run(1'b1, 5, "to_start");
    n = 1;
    while (bus.oRunStart === 1'b1 && n < 5000) begin
      @(negedge clk);
      if (bus.oRunStart === 1'b1) n++;
    end
    check_eq("to_run_cycles", 32'(n), 32'd4096);
    check_eq("to_tmo_cnt", 32'(bus.oTimeoutCnt), 32'd1);
    check_eq("to_frame_cnt", 32'(bus.oFrameCnt), 32'd4);
    check_eq("to_bank_freed", 32'(bus.oRxBankValid), 32'd1);
    check_eq("to_rd_bank", 32'(bus.oRdBank), 32'd1);

    // Reset applied during RUN with both banks queued.
    step(3);
    rx(77, 1'b1, 1'b1);
    wait_run(1'b1, 5, "rs_start");
    step(1);
    rx(88, 1'b1, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("rs_run_start", 32'(bus.oRunStart), 32'd0);
    check_eq("rs_bank_valid", 32'(bus.oRxBankValid), 32'd1);
    check_eq("rs_rx_bank", 32'(bus.oRxBank), 32'd0);
    check_eq("rs_rd_bank", 32'(bus.oRdBank), 32'd0);
    check_eq("rs_tx_len", 32'(bus.oTxLen), 32'd0);
    check_eq("rs_drop", 32'(bus.oDropCnt), 32'd0);
    check_eq("rs_tmo", 32'(bus.oTimeoutCnt), 32'd0);
    check_eq("rs_frame", 32'(bus.oFrameCnt), 32'd0);
    step(3);
    @(negedge clk);
    check_eq("rs_banks_discarded", 32'(bus.oRunStart), 32'd0);
    check_eq("rs_idle", 32'(bus.oBusy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
